// File: rtl/transfer_center_rx.sv
// Serial command/data receiver: assembles MSB-first words, decodes control-station
// commands and buffers binary/ASCII payload words in a DEPTH-entry FIFO.
module transfer_center_rx #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dataIn,
  input  logic              dataValid,
  input  logic              readyForTransferIn,
  output logic              readyForTransferOut,
  output logic [1:0]        localScannerOut,
  output logic [WORD_W-1:0] dataOut,
  output logic              dataOutValid,
  input  logic              dataOutRead,
  output logic              dataIsAscii,
  output logic [CNT_W-1:0]  fifoCount,
  output logic              overflow
);

  localparam int BIT_W = $clog2(WORD_W);
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {CMD, LEN, DATA} state_t;

  state_t              state, state_nxt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [WORD_W-2:0]   shift;
  logic [WORD_W-1:0]   word;
  logic                done;
  logic [WORD_W-1:0]   remaining, remaining_nxt;
  logic                ready, ready_nxt, ascii_nxt;
  logic [1:0]          scan_nxt;
  logic                push, flush, pop, full, empty, wr_en;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [WORD_W-1:0]   mem [DEPTH];

  assign word = {shift, dataIn};
  assign done = dataValid && (bit_cnt == BIT_W'(WORD_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (dataValid) begin
      shift   <= word[WORD_W-2:0];
      bit_cnt <= done ? '0 : bit_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    ready_nxt     = ready;
    ascii_nxt     = dataIsAscii;
    scan_nxt      = 2'b00;
    push          = 1'b0;
    flush         = 1'b0;
    if (done) begin
      case (state)
        CMD: begin
          case (word)
            WORD_W'(1): begin ready_nxt = 1'b0; scan_nxt = 2'b10; end
            WORD_W'(2), WORD_W'(4): ready_nxt = readyForTransferIn;
            WORD_W'(3): begin ready_nxt = readyForTransferIn; scan_nxt = 2'b01; end
            WORD_W'(5): flush = 1'b1;
            WORD_W'(7), WORD_W'(8): begin
              ready_nxt = readyForTransferIn;
              ascii_nxt = (word == WORD_W'(8));
              state_nxt = LEN;
            end
            default: ;
          endcase
        end
        LEN: begin
          if (word == '0) begin
            state_nxt = CMD;
          end else begin
            remaining_nxt = word;
            state_nxt     = DATA;
          end
        end
        DATA: begin
          // Dropped words on overflow still consume the payload length.
          push          = 1'b1;
          remaining_nxt = remaining - 1'b1;
          if (remaining == WORD_W'(1)) state_nxt = CMD;
        end
        default: state_nxt = CMD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= CMD;
      remaining       <= '0;
      ready           <= 1'b0;
      dataIsAscii     <= 1'b0;
      localScannerOut <= 2'b00;
    end else begin
      state           <= state_nxt;
      remaining       <= remaining_nxt;
      ready           <= ready_nxt;
      dataIsAscii     <= ascii_nxt;
      localScannerOut <= scan_nxt;
    end
  end

  assign empty = (fifoCount == '0);
  assign full  = (fifoCount == CNT_W'(DEPTH));
  assign pop   = dataOutRead && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO is accepted.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifoCount <= '0;
      overflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifoCount <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && !wr_en) overflow <= 1'b1;
      case ({wr_en, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= word;
  end

  assign dataOut             = empty ? '0 : mem[rd_ptr];
  assign dataOutValid        = !empty;
  assign readyForTransferOut = ready && !full;

endmodule

// File: tb/tb_transfer_center_rx.sv
// Bench for transfer_center_rx: command table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_transfer_center_rx;

  logic       clk = 1'b0;
  logic       rst, dataIn, dataValid, readyForTransferIn, dataOutRead;
  logic       readyForTransferOut, dataOutValid, dataIsAscii, overflow;
  logic [1:0] localScannerOut;
  logic [7:0] dataOut;
  logic [4:0] fifoCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  transfer_center_rx #(.WORD_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .dataIn(dataIn), .dataValid(dataValid),
    .readyForTransferIn(readyForTransferIn), .readyForTransferOut(readyForTransferOut),
    .localScannerOut(localScannerOut), .dataOut(dataOut), .dataOutValid(dataOutValid),
    .dataOutRead(dataOutRead), .dataIsAscii(dataIsAscii), .fifoCount(fifoCount),
    .overflow(overflow)
  );

  // Reference model: mode 0 = command, 1 = length, 2 = payload.
  int         m_mode, m_left;
  bit         m_ready, m_ascii, m_ovf;
  logic [1:0] m_scan;
  logic [7:0] q[$];

  function automatic void model_reset();
    m_mode = 0; m_left = 0; m_ready = 0; m_ascii = 0; m_ovf = 0; m_scan = 2'b00;
    q.delete();
  endfunction

  function automatic void model_word(input logic [7:0] w, input bit rin, input bit pop_same);
    m_scan = 2'b00;
    if (pop_same && q.size() > 0) void'(q.pop_front());
    if (m_mode == 0) begin
      case (w)
        8'd1: begin m_ready = 0; m_scan = 2'b10; end
        8'd2, 8'd4: m_ready = rin;
        8'd3: begin m_ready = rin; m_scan = 2'b01; end
        8'd5: begin q.delete(); m_ovf = 0; end
        8'd7, 8'd8: begin m_ready = rin; m_ascii = (w == 8'd8); m_mode = 1; end
        default: ;
      endcase
    end else if (m_mode == 1) begin
      if (w == 0) m_mode = 0;
      else begin m_left = w; m_mode = 2; end
    end else begin
      if (q.size() < 16) q.push_back(w);
      else m_ovf = 1;
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ready"}, readyForTransferOut, (m_ready && q.size() != 16));
    check({tag, ".scan"},  localScannerOut, m_scan);
    check({tag, ".data"},  dataOut, (q.size() > 0) ? q[0] : 8'h00);
    check({tag, ".valid"}, dataOutValid, (q.size() > 0));
    check({tag, ".ascii"}, dataIsAscii, m_ascii);
    check({tag, ".count"}, fifoCount, q.size());
    check({tag, ".ovf"},   overflow, m_ovf);
    m_scan = 2'b00;
  endtask

  // Shifts one word MSB first; returns at the negedge after the final-bit edge.
  task automatic shift_word(input logic [7:0] w, input bit rin, input int gap_max, input bit pop_last);
    readyForTransferIn = rin;
    for (int i = 7; i >= 0; i--) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          dataValid = 1'b0; dataIn = 1'($urandom); @(negedge clk);
        end
      end
      dataIn = w[i]; dataValid = 1'b1; dataOutRead = pop_last && (i == 0);
      @(negedge clk);
    end
    dataValid = 1'b0; dataOutRead = 1'b0;
    model_word(w, rin, pop_last);
  endtask

  task automatic pop_one();
    dataOutRead = 1'b1;
    @(negedge clk);
    dataOutRead = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  typedef struct {
    logic [7:0] w;
    bit         rin;
    logic [1:0] scan;
    bit         rdy;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{'{8'h01, 1, 2'b10, 0}, '{8'h03, 1, 2'b01, 1}, '{8'h06, 0, 2'b00, 1},
            '{8'h01, 0, 2'b10, 0}, '{8'h02, 1, 2'b00, 1}, '{8'h09, 0, 2'b00, 1},
            '{8'h04, 0, 2'b00, 0}, '{8'h03, 0, 2'b01, 0}, '{8'h00, 1, 2'b00, 0},
            '{8'h04, 1, 2'b00, 1}, '{8'hFF, 0, 2'b00, 1}};

    rst = 1'b0; dataIn = 0; dataValid = 0; readyForTransferIn = 0; dataOutRead = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    check("reset.count_const", fifoCount, 0);
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      shift_word(tbl[i].w, tbl[i].rin, 0, 0);
      check("tbl.scan", localScannerOut, tbl[i].scan);
      check("tbl.ready", readyForTransferOut, tbl[i].rdy);
      m_scan = 2'b00;
      @(negedge clk);
      check("tbl.scan_end", localScannerOut, 2'b00);
    end

    // ASCII payload with gaps in dataValid
    shift_word(8'h08, 1, 3, 0);
    shift_word(8'h03, 1, 3, 0);
    shift_word(8'h41, 1, 3, 0);
    shift_word(8'h42, 1, 3, 0);
    shift_word(8'h43, 1, 3, 0);
    check_all("ascii");
    check("ascii.flag", dataIsAscii, 1);
    check("ascii.count", fifoCount, 3);
    check("ascii.head", dataOut, 8'h41);
    for (int k = 0; k < 3; k++) begin
      check("ascii.pop", dataOut, 8'h41 + k);
      pop_one();
    end
    check("ascii.empty", dataOutValid, 0);
    check("ascii.empty_data", dataOut, 0);

    // Overflow with 18 payload words, then flush
    shift_word(8'h07, 1, 0, 0);
    shift_word(8'd18, 1, 0, 0);
    for (int k = 0; k < 18; k++) shift_word(8'($urandom), 1, 0, 0);
    check_all("ovf");
    check("ovf.count", fifoCount, 16);
    check("ovf.ready", readyForTransferOut, 0);
    check("ovf.flag", overflow, 1);
    shift_word(8'h05, 0, 0, 0);
    check("flush.count", fifoCount, 0);
    check("flush.ovf", overflow, 0);
    check_all("flush");

    // Full FIFO: pop on the same edge a payload word completes
    shift_word(8'h07, 1, 0, 0);
    shift_word(8'd17, 1, 0, 0);
    for (int k = 0; k < 16; k++) shift_word(8'(k + 8'h10), 1, 0, 0);
    check("full.count", fifoCount, 16);
    shift_word(8'hA5, 1, 0, 1);
    check("fullpop.count", fifoCount, 16);
    check("fullpop.ovf", overflow, 0);
    check_all("fullpop");
    for (int k = 0; k < 16; k++) begin
      if (k == 15) check("fullpop.last", dataOut, 8'hA5);
      else check("fullpop.drain", dataOut, 8'(k + 8'h11));
      pop_one();
    end
    check("fullpop.empty", fifoCount, 0);

    // Reset mid-word
    for (int k = 0; k < 4; k++) begin dataIn = 1; dataValid = 1; @(negedge clk); end
    rst = 1'b0; dataValid = 0;
    #1;
    model_reset();
    check_all("rst_word");
    @(negedge clk);
    rst = 1'b1;
    shift_word(8'h03, 1, 0, 0);
    check("rst_word.scan", localScannerOut, 2'b01);
    check("rst_word.ready", readyForTransferOut, 1);
    m_scan = 2'b00;

    // Reset mid-payload
    shift_word(8'h07, 1, 0, 0);
    shift_word(8'h05, 1, 0, 0);
    shift_word(8'hAA, 1, 0, 0);
    shift_word(8'hBB, 1, 0, 0);
    check("rst_pay.count", fifoCount, 2);
    for (int k = 0; k < 3; k++) begin dataIn = 0; dataValid = 1; @(negedge clk); end
    rst = 1'b0; dataValid = 0;
    #1;
    model_reset();
    check_all("rst_pay");
    @(negedge clk);
    rst = 1'b1;
    shift_word(8'h01, 1, 0, 0);
    check("rst_pay.scan", localScannerOut, 2'b10);
    check_all("rst_pay.next");

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      shift_word(8'($urandom_range(10, 0)), 1'($urandom), $urandom_range(2, 0), 0);
      check_all("rnd.cmd");
      if (m_mode == 1) begin
        shift_word(8'($urandom_range(20, 0)), 1'($urandom), $urandom_range(2, 0), 0);
        check_all("rnd.len");
        while (m_mode == 2) begin
          shift_word(8'($urandom), 1'($urandom), $urandom_range(1, 0), ($urandom_range(3, 0) == 0));
          check_all("rnd.pay");
        end
      end
      repeat ($urandom_range(3, 0)) begin
        pop_one();
        check_all("rnd.pop");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transfer_center_rx.md
# transfer_center_rx

Parametrised serial command/data receiver for the transfer centre. It assembles a qualified serial bit stream into WORD_W-bit words and decodes each word as a control-station command. It drives the transfer-ready handshake and local-scanner control, and stores binary/ASCII payload words in an internal DEPTH-entry FIFO that the downstream consumer reads through a valid/read handshake.

## Interface
- WORD_W, 8: bits per serial word; command codes occupy the low bits, zero-extended.
- DEPTH, 16: payload FIFO depth in words; must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1: width of fifoCount (derived).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- dataIn  in  1  serial bit, MSB first.
- dataValid  in  1  qualifies dataIn; a bit is shifted only on edges where dataValid=1.
- readyForTransferIn  in  1  upstream ready, forwarded on selected commands.
- readyForTransferOut  out  1  ready to the control station.
- localScannerOut  out  2  scanner control: 00 idle, 10 flush, 01 start.
- dataOut  out  WORD_W  FIFO head word; 0 when empty.
- dataOutValid  out  1  FIFO not empty.
- dataOutRead  in  1  pops the head on an edge where dataOutValid=1.
- dataIsAscii  out  1  payload type of the most recent data command.
- fifoCount  out  CNT_W  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a payload word was dropped.

## Operation
- Word assembly: shift register plus bit counter (0..WORD_W-1). The edge that samples the WORD_W-th valid bit completes the word {shift[WORD_W-2:0], dataIn}. The counter wraps to 0 on that edge. Gaps in dataValid hold the counter; there is no timeout.
- FSM states: CMD, LEN, DATA. Completed words are interpreted according to the current state.
- CMD state, completed word decodes as follows:
  - 1 (buffer 50%): ready latch <= 0; localScannerOut=10 for one cycle.
  - 2 (buffer 80%) and 4 (buffer full): ready latch <= readyForTransferIn.
  - 3 (buffer 90%): ready latch <= readyForTransferIn; localScannerOut=01 for one cycle.
  - 5 (flush): FIFO emptied, overflow cleared.
  - 6 (ready query): no effect.
  - 7 / 8 (binary / ASCII data follows): ready latch <= readyForTransferIn; dataIsAscii <= 0 / 1; go to LEN.
  - Any other value: ignored; stay in CMD.
- LEN state: the completed word is the payload length L. L=0 returns to CMD. Otherwise remaining <= L and go to DATA.
- DATA state: each completed word is pushed to the FIFO and remaining is decremented. When the last word is taken, go to CMD. Payload words are never decoded as commands.
- Push while full: the word is dropped and overflow <= 1. The word still counts against remaining.
- readyForTransferOut = ready latch AND NOT (fifoCount==DEPTH).
- Simultaneous push and pop: both take effect, fifoCount unchanged. This holds when full too: the pop frees the slot and the push is accepted, no overflow.
- Pop while empty: ignored.
- Flush command on the same edge as a pop: flush wins, fifoCount=0.
- FIFO pointers wrap modulo DEPTH. fifoCount saturates structurally at DEPTH.

## Timing
- Reset (rst=0, asynchronous) sets:
  - state CMD, bit counter 0, shift register 0, remaining 0, ready latch 0;
  - readyForTransferOut 0, localScannerOut 00, dataOut 0, dataOutValid 0, dataIsAscii 0, fifoCount 0, overflow 0.
- Reset mid-word or mid-payload discards the partial word and the FIFO contents.
- Command effects are registered on the same edge that samples the final bit and are visible in the following cycle.
- localScannerOut pulses are exactly one cycle wide. Back-to-back commands can produce consecutive pulses.
- A pushed payload word appears on dataOut and dataOutValid one cycle after its final-bit edge.
- After a pop, dataOut shows the next entry in the following cycle.
- The bit stream sustains one bit per cycle with no bubbles between words.

## Test plan
- Reset, then shift 8'h01 with readyForTransferIn=1: localScannerOut=10 for one cycle; readyForTransferOut stays 0.
- Shift 8'h03 with readyForTransferIn=1: readyForTransferOut=1 the cycle after the last bit; localScannerOut=01 for exactly one cycle, then 00.
- Shift 8'h08, 8'h03, then 8'h41, 8'h42, 8'h43 with dataValid gaps: dataIsAscii=1, fifoCount=3, dataOut=8'h41; three pops return 41, 42, 43; dataOutValid=0 afterwards.
- Shift 8'h07 and length 8'd18 with DEPTH=16 and no reads: fifoCount=16, readyForTransferOut=0, overflow=1. A following 8'h05 gives fifoCount=0 and overflow=0.
- With the FIFO full, assert dataOutRead on the same edge a payload word completes: fifoCount stays 16, overflow stays 0, and the new word is read out last.
- Pull rst low mid-word and mid-payload: all outputs return to reset values immediately. The next full command word decodes normally.
